set_job_driver: RTL and testbench

//  Initiator for the SET circle-intersection engine. Takes jobs (central, radius) from an upstream

---
 rtl/set_pkg.sv | 13 +
 rtl/set_job_driver_if.sv | 42 ++++
 rtl/set_sync_fifo.sv | 48 ++++
 rtl/set_job_driver.sv | 142 ++++++++++++++
 tb/tb_set_job_driver.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/set_pkg.sv
// Shared widths and FSM encoding for the SET job driver.
package set_pkg;
   localparam int COORD_W   = 4;
   localparam int CAND_W    = 8;
   localparam int CENTRAL_W = 16;
   localparam int RADIUS_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } set_state_e;
endpackage

// File: rtl/set_job_driver_if.sv
// Job stream, SET engine bus and result stream of the SET job driver.
interface set_job_driver_if #(
   parameter int TAG_W = 4
);
   import set_pkg::*;

   logic                 job_valid;
   logic                 job_ready;
   logic [CENTRAL_W-1:0] job_central;
   logic [RADIUS_W-1:0]  job_radius;

   logic                 set_en;
   logic [CENTRAL_W-1:0] set_central;
   logic [RADIUS_W-1:0]  set_radius;
   logic                 set_busy;
   logic                 set_valid;
   logic [CAND_W-1:0]    set_candidate;

   logic                 res_valid;
   logic                 res_ready;
   logic [CAND_W-1:0]    res_candidate;
   logic [TAG_W-1:0]     res_tag;
   logic                 res_timeout;

   // Driver side.
   modport master (
      input  job_valid, job_central, job_radius,
      input  set_busy, set_valid, set_candidate,
      input  res_ready,
      output job_ready, set_en, set_central, set_radius,
      output res_valid, res_candidate, res_tag, res_timeout
   );

   // Job source, SET engine and result sink side.
   modport slave (
      output job_valid, job_central, job_radius,
      output set_busy, set_valid, set_candidate,
      output res_ready,
      input  job_ready, set_en, set_central, set_radius,
      input  res_valid, res_candidate, res_tag, res_timeout
   );
endinterface

// File: rtl/set_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; push and pop may coincide at any fill level.
module set_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_din,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_dout,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr;
   logic             w_rd;

   assign w_rd = i_pop && (r_count != '0);
   assign w_wr = i_push && ((r_count != CW'(DEPTH)) || w_rd);

   // Storage; entries are meaningless until written, so no reset.
   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr_ptr] <= i_din;

   // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
endmodule

// File: rtl/set_job_driver.sv
// Buffers circle jobs, issues them one at a time to a SET engine, and returns tagged results
// with timeout and protocol-error detection.
module set_job_driver
   import set_pkg::*;
#(
   parameter int JOB_DEPTH = 4,
   parameter int RES_DEPTH = 4,
   parameter int TAG_W     = 4,
   parameter int TIMEOUT   = 511
) (
   input  logic              clk,
   input  logic              rst,
   set_job_driver_if.master  bus,
   output logic              err_busy,
   output logic              err_stray,
   output logic [15:0]       jobs_done
);
   localparam int JW   = CENTRAL_W + RADIUS_W + TAG_W;
   localparam int RW   = CAND_W + TAG_W + 1;
   localparam int WC_W = $clog2(TIMEOUT + 1);

   set_state_e               r_state, w_next;
   logic                     r_up;
   logic [TAG_W-1:0]         r_tag_cnt;
   logic [TAG_W-1:0]         r_tag;
   logic [CENTRAL_W-1:0]     r_central;
   logic [RADIUS_W-1:0]      r_radius;
   logic [WC_W-1:0]          r_wait_cnt;
   logic                     r_busy_lo;
   logic                     r_err_busy;
   logic                     r_err_stray;
   logic [15:0]              r_jobs_done;

   logic                     w_job_push, w_job_pop, w_job_empty, w_job_full;
   logic [JW-1:0]            w_job_dout;
   logic [$clog2(JOB_DEPTH):0] w_job_cnt;
   logic                     w_res_push, w_res_pop, w_res_empty, w_slot_free;
   logic [RW-1:0]            w_res_din, w_res_dout;
   logic [$clog2(RES_DEPTH):0] w_res_cnt;
   logic                     w_set_en;

   assign w_job_full  = (int'(w_job_cnt) == JOB_DEPTH);
   assign w_job_push  = bus.job_valid && bus.job_ready;
   assign w_res_pop   = bus.res_valid && bus.res_ready;
   // A result slot is reserved for the job in flight, so a pushed result can never overflow.
   assign w_slot_free = (int'(w_res_cnt) + int'(r_state != S_IDLE)) < RES_DEPTH;

   set_sync_fifo #(.WIDTH(JW), .DEPTH(JOB_DEPTH)) u_job_fifo (
      .clk(clk), .rst(rst),
      .i_push(w_job_push), .i_din({bus.job_central, bus.job_radius, r_tag_cnt}),
      .i_pop(w_job_pop), .o_dout(w_job_dout), .o_count(w_job_cnt), .o_empty(w_job_empty)
   );

   set_sync_fifo #(.WIDTH(RW), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk(clk), .rst(rst),
      .i_push(w_res_push), .i_din(w_res_din),
      .i_pop(w_res_pop), .o_dout(w_res_dout), .o_count(w_res_cnt), .o_empty(w_res_empty)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next state, job pop, SET start pulse and result push; a valid strobe beats a same-cycle timeout.
   always_comb begin
      w_next     = r_state;
      w_job_pop  = 1'b0;
      w_res_push = 1'b0;
      w_res_din  = '0;
      w_set_en   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_job_empty && w_slot_free) begin
               w_job_pop = 1'b1;
               w_next    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_set_en = 1'b1;
            w_next   = S_WAIT;
         end
         S_WAIT: begin
            if (bus.set_valid) begin
               w_res_push = 1'b1;
               w_res_din  = {bus.set_candidate, r_tag, 1'b0};
               w_next     = S_IDLE;
            end else if (r_wait_cnt == WC_W'(TIMEOUT)) begin
               w_res_push = 1'b1;
               w_res_din  = {{CAND_W{1'b0}}, r_tag, 1'b1};
               w_next     = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Job capture, tag allocation and WAIT cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_up       <= 1'b0;
         r_tag_cnt  <= '0;
         r_tag      <= '0;
         r_central  <= '0;
         r_radius   <= '0;
         r_wait_cnt <= '0;
      end else begin
         r_up <= 1'b1;
         if (w_job_push) r_tag_cnt <= r_tag_cnt + TAG_W'(1);
         if (w_job_pop) {r_central, r_radius, r_tag} <= w_job_dout;
         if (r_state == S_ISSUE)     r_wait_cnt <= '0;
         else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + WC_W'(1);
      end
   end

   // Sticky protocol errors and completed-job counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy_lo   <= 1'b0;
         r_err_busy  <= 1'b0;
         r_err_stray <= 1'b0;
         r_jobs_done <= '0;
      end else begin
         r_busy_lo <= (r_state == S_WAIT) && (r_wait_cnt == '0) && !bus.set_busy;
         if ((r_state == S_WAIT) && (r_wait_cnt == WC_W'(1)) && !bus.set_busy && r_busy_lo)
            r_err_busy <= 1'b1;
         if (bus.set_valid && (r_state != S_WAIT)) r_err_stray <= 1'b1;
         if (w_res_push) r_jobs_done <= r_jobs_done + 16'd1;
      end
   end

   assign bus.job_ready   = r_up && !w_job_full;
   assign bus.set_en      = w_set_en;
   assign bus.set_central = r_central;
   assign bus.set_radius  = r_radius;
   assign bus.res_valid   = !w_res_empty;
   assign {bus.res_candidate, bus.res_tag, bus.res_timeout} = w_res_empty ? '0 : w_res_dout;
   assign err_busy        = r_err_busy;
   assign err_stray       = r_err_stray;
   assign jobs_done       = r_jobs_done;
endmodule

// File: tb/tb_set_job_driver.sv
// Bench for set_job_driver: behavioural SET engine, queue-based reference of expected results.
`timescale 1ns/1ps
module tb_set_job_driver;
   import set_pkg::*;

   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 511;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        err_busy, err_stray;
   logic [15:0] jobs_done;

   always #5 clk = ~clk;

   set_job_driver_if #(.TAG_W(TAG_W)) bus ();

   set_job_driver #(.JOB_DEPTH(4), .RES_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .bus(bus), .err_busy(err_busy), .err_stray(err_stray), .jobs_done(jobs_done)
   );

   // SET engine model configuration (written by the stimulus, read by the model).
   int          m_lat = 20;
   bit          m_never, m_busy_low, m_busy_hold, m_cand_fixed;
   logic [7:0]  m_cand;
   bit          m_stray_req;

   // Behavioural SET: busy after en, one valid strobe m_lat cycles after the en cycle.
   int          m_cnt;
   bit          m_pend, m_stray_ack;
   logic [23:0] m_job;
   always @(negedge clk) begin
      if (rst) begin
         m_cnt = 0; m_pend = 0;
         bus.set_valid = 1'b0; bus.set_busy = 1'b0; bus.set_candidate = '0;
      end else begin
         bus.set_valid = 1'b0;
         if (m_stray_req != m_stray_ack) begin
            m_stray_ack = m_stray_req;
            bus.set_valid = 1'b1;
            bus.set_candidate = 8'hEE;
         end
         if (bus.set_en) begin
            m_job = {bus.set_central, bus.set_radius};
            m_cnt = m_lat; m_pend = 1;
            bus.set_busy = !m_busy_low;
         end else if (m_pend) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_pend = 0;
               if (!m_never) begin
                  bus.set_valid = 1'b1;
                  bus.set_candidate = m_cand_fixed ? m_cand : (m_job[15:8] ^ m_job[7:0]);
               end
               if (!m_busy_hold) bus.set_busy = 1'b0;
            end
         end
      end
   end

   // Issue monitor: every set_en pulse with the values it carried.
   logic [23:0] q_iss[$];
   int          n_en = 0;
   bit          en_prev = 0, en_double = 0;
   always @(negedge clk) begin
      if (bus.set_en) begin
         q_iss.push_back({bus.set_central, bus.set_radius});
         n_en++;
         if (en_prev) en_double = 1;
      end
      en_prev = bus.set_en;
   end

   // Reference: accepted jobs in order, with the result each must produce.
   typedef struct {
      logic [15:0] c;
      logic [7:0]  r;
      logic [3:0]  tag;
      logic [7:0]  cand;
      logic        to;
   } exp_t;
   exp_t q_exp[$];
   int   n_acc, iss_idx;
   int   n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   task automatic push_job(input logic [15:0] c, input logic [7:0] r, output bit stalled);
      int   w = 0;
      exp_t e;
      stalled = 0;
      bus.job_valid = 1'b1; bus.job_central = c; bus.job_radius = r;
      while (!bus.job_ready && w < 2000) begin stalled = 1; @(negedge clk); w++; end
      chk("job_accept", bus.job_ready, 1);
      @(negedge clk);
      bus.job_valid = 1'b0;
      e.c = c; e.r = r; e.tag = 4'(n_acc % 16); e.to = m_never;
      e.cand = m_never ? 8'd0 : (m_cand_fixed ? m_cand : (c[7:0] ^ r));
      q_exp.push_back(e);
      n_acc++;
   endtask

   task automatic wait_res(input string nm, output int cnt);
      cnt = 0;
      while (!bus.res_valid && cnt < 2000) begin @(negedge clk); cnt++; end
      chk({nm, "_res_valid"}, bus.res_valid, 1);
   endtask

   task automatic wait_en(input string nm);
      int w = 0;
      while (!bus.set_en && w < 200) begin @(negedge clk); w++; end
      chk({nm, "_set_en"}, bus.set_en, 1);
   endtask

   task automatic pop_res(input string nm);
      int          cnt;
      exp_t        e;
      logic [23:0] iss;
      wait_res(nm, cnt);
      chk({nm, "_exp_pending"}, 32'(q_exp.size() > 0), 1);
      if (q_exp.size() > 0) begin
         e = q_exp.pop_front();
         chk({nm, "_result"}, {bus.res_candidate, bus.res_tag, bus.res_timeout}, {e.cand, e.tag, e.to});
         iss = (iss_idx < q_iss.size()) ? q_iss[iss_idx] : 24'hxxxxxx;
         chk({nm, "_issued"}, iss, {e.c, e.r});
         iss_idx++;
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      q_exp.delete();
      n_acc = 0;
      iss_idx = q_iss.size();
      m_lat = 5; m_never = 0; m_busy_low = 0; m_busy_hold = 0; m_cand_fixed = 0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit   st, st_any;
      int   cnt, en0;
      bus.job_valid = 1'b0; bus.job_central = '0; bus.job_radius = '0; bus.res_ready = 1'b0;
      m_stray_req = 0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_job_ready", bus.job_ready, 0);
      chk("rst_outputs", {bus.set_en, bus.set_central, bus.set_radius, bus.res_valid, bus.res_candidate,
                          bus.res_tag, bus.res_timeout, err_busy, err_stray, jobs_done}, 0);
      rst = 1'b0;
      chk("rst_release_ready", bus.job_ready, 0);
      @(negedge clk);
      chk("rst_ready_rise", bus.job_ready, 1);
      n_acc = 0; iss_idx = 0;

      // 1: single job, latency 20, fixed candidate 21
      m_lat = 20; m_cand_fixed = 1; m_cand = 8'd21;
      push_job(16'h4466, 8'h33, st);
      chk("t1_en_before", bus.set_en, 0);
      @(negedge clk);
      chk("t1_en", bus.set_en, 1);
      chk("t1_set_bus", {bus.set_central, bus.set_radius}, 24'h446633);
      wait_res("t1", cnt);
      chk("t1_latency", cnt, 21);
      chk("t1_held", {bus.set_central, bus.set_radius}, 24'h446633);
      chk("t1_jobs_done", jobs_done, 1);
      pop_res("t1");
      chk("t1_errs", {err_busy, err_stray}, 0);

      // 2: six jobs back-to-back, result sink stalled
      do_reset();
      m_lat = 3;
      en0 = n_en; st_any = 0;
      for (int i = 0; i < 6; i++) begin
         push_job(16'($urandom), 8'($urandom), st);
         st_any |= st;
      end
      chk("t2_job_ready_dropped", st_any, 1);
      repeat (60) @(negedge clk);
      chk("t2_four_issued", n_en - en0, 4);
      chk("t2_jobs_done", jobs_done, 4);
      chk("t2_res_valid", bus.res_valid, 1);
      for (int i = 0; i < 6; i++) pop_res("t2");
      repeat (5) @(negedge clk);
      chk("t2_six_issued", n_en - en0, 6);
      chk("t2_drained", bus.res_valid, 0);

      // 3: engine never answers -> timeout, then a late strobe is flagged
      do_reset();
      m_never = 1;
      push_job(16'h1234, 8'h56, st);
      wait_en("t3");
      wait_res("t3", cnt);
      chk("t3_timeout_latency", cnt, TIMEOUT + 2);
      pop_res("t3");
      chk("t3_no_stray_yet", err_stray, 0);
      m_stray_req = ~m_stray_req;
      repeat (4) @(negedge clk);
      chk("t3_err_stray", err_stray, 1);
      chk("t3_stray_dropped", {bus.res_valid, jobs_done}, {1'b0, 16'd1});

      // 4: early exit with busy left high; next job still issues
      do_reset();
      m_lat = 4; m_busy_hold = 1;
      en0 = n_en;
      push_job(16'($urandom), 8'($urandom), st);
      push_job(16'($urandom), 8'($urandom), st);
      pop_res("t4");
      pop_res("t4");
      chk("t4_issued", n_en - en0, 2);
      chk("t4_errs", {err_busy, err_stray}, 0);

      // 5: busy never rises -> err_busy by the second cycle after set_en
      do_reset();
      m_lat = 6; m_busy_low = 1;
      push_job(16'hABCD, 8'hEF, st);
      wait_en("t5");
      repeat (2) @(negedge clk);
      chk("t5_err_busy_early", err_busy, 0);
      @(negedge clk);
      chk("t5_err_busy", err_busy, 1);
      pop_res("t5");

      // 6: reset mid-WAIT discards the job; then 17 jobs to see the tag wrap
      do_reset();
      m_lat = 30;
      push_job(16'($urandom), 8'($urandom), st);
      wait_en("t6");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_outputs", {bus.job_ready, bus.set_en, bus.set_central, bus.set_radius, bus.res_valid,
                             bus.res_candidate, bus.res_tag, bus.res_timeout, err_busy, err_stray, jobs_done}, 0);
      @(negedge clk);
      rst = 1'b0;
      q_exp.delete(); n_acc = 0; iss_idx = q_iss.size();
      en0 = n_en;
      repeat (40) @(negedge clk);
      chk("t6_no_result", {bus.res_valid, jobs_done}, 0);
      chk("t6_no_reissue", n_en - en0, 0);
      m_lat = 2;
      for (int i = 0; i < 17; i++) begin
         push_job(16'($urandom), 8'($urandom), st);
         if (i == 16) begin
            wait_res("t6_wrap", cnt);
            chk("t6_tag_wrap", bus.res_tag, 0);
         end
         pop_res("t6");
      end
      chk("t6_jobs_done", jobs_done, 17);

      chk("set_en_single_cycle", en_double, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
